seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver that follows an upstream one-hot scan ring.
// It buffers a pending BCD value until the frame boundary and drops to blank/fault on phase errors.
module seg_scan_driver #(
  parameter int unsigned ERR_LIMIT = 3,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  phase_in,
  input  logic [15:0] data_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        frame_done,
  output logic        phase_err,
  output logic [1:0]  err_cnt
);

  typedef enum logic [1:0] {StWaitSync, StRun, StFault} state_e;

  localparam logic [1:0] ErrLimit = 2'(ERR_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  prev_q, prev_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_done_q, frame_done_d;
  logic        phase_err_q, phase_err_d;
  logic [1:0]  err_cnt_q, err_cnt_d;

  logic       is_stall, is_step, is_bad, is_boundary;
  logic [1:0] err_inc;
  logic [3:0] digit_val;
  logic       digit_lz;
  logic [6:0] digit_seg;
  logic       lz3, lz2, lz1;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign is_stall    = (phase_in == prev_q);
  assign is_step     = (phase_in == {prev_q[2:0], prev_q[3]});
  assign is_bad      = (state_q == StRun) && !is_stall && !is_step;
  assign is_boundary = (state_q == StRun) && is_step && (prev_q == 4'b1000);
  assign err_inc     = (err_cnt_q == 2'd3) ? 2'd3 : err_cnt_q + 2'd1;
  assign load_ready  = ~pend_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitSync;
      prev_q       <= 4'b0001;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
      phase_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      phase_err_q  <= phase_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitSync: if (phase_in == 4'b0001) state_d = StRun;
      StRun:      if (is_bad) state_d = (err_inc >= ErrLimit) ? StFault : StWaitSync;
      StFault:    state_d = StFault;
      default:    state_d = StWaitSync;
    endcase
  end

  // Load and boundary never collide: a load needs pend empty, a copy needs it full.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (load_valid && load_ready) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end
    if (is_boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
  end

  assign lz3 = (disp_d[15:12] == 4'd0);
  assign lz2 = lz3 && (disp_d[11:8] == 4'd0);
  assign lz1 = lz2 && (disp_d[7:4] == 4'd0);

  // Decode from disp_d so the boundary digit already shows the freshly copied value.
  always_comb begin
    digit_val = disp_d[3:0];
    digit_lz  = 1'b0;
    case (phase_in)
      4'b0010: begin digit_val = disp_d[7:4];   digit_lz = lz1; end
      4'b0100: begin digit_val = disp_d[11:8];  digit_lz = lz2; end
      4'b1000: begin digit_val = disp_d[15:12]; digit_lz = lz3; end
      default: ;
    endcase
    digit_seg = (LZ_BLANK && digit_lz) ? 7'h7F : bcd_to_seg(digit_val);
  end

  always_comb begin
    prev_d       = prev_q;
    an_d         = an_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      StWaitSync: begin
        if (phase_in == 4'b0001) begin
          prev_d = 4'b0001;
          an_d   = 4'b1110;
          seg_d  = digit_seg;
        end else begin
          an_d  = 4'hF;
          seg_d = 7'h7F;
        end
      end
      StRun: begin
        if (is_stall) begin
          prev_d = prev_q;
        end else if (is_step) begin
          prev_d       = phase_in;
          an_d         = ~phase_in;
          seg_d        = digit_seg;
          frame_done_d = is_boundary;
        end else begin
          err_cnt_d = err_inc;
          an_d      = 4'hF;
          seg_d     = 7'h7F;
        end
      end
      default: begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
      end
    endcase
    phase_err_d = (state_d == StFault);
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_done_q;
  assign phase_err  = phase_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan, load handoff, blanking, stall, errors, fault and reset.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  phase_in;
  logic [15:0] data_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        frame_done;
  logic        phase_err;
  logic [1:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .ERR_LIMIT (3),
    .LZ_BLANK  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .phase_in   (phase_in),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .frame_done (frame_done),
    .phase_err  (phase_err),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] ph, input logic [3:0] an_exp,
                      input logic [6:0] seg_exp, input logic fd_exp);
    phase_in = ph;
    tick();
    check({tag, ".an"}, 16'(an_out), 16'(an_exp));
    check({tag, ".seg"}, 16'(seg_out), 16'(seg_exp));
    check({tag, ".fd"}, 16'(frame_done), 16'(fd_exp));
  endtask

  task automatic check_err(input string tag, input logic [1:0] cnt_exp, input logic pe_exp);
    check({tag, ".cnt"}, 16'(err_cnt), 16'(cnt_exp));
    check({tag, ".pe"}, 16'(phase_err), 16'(pe_exp));
  endtask

  initial begin
    reset      = 1'b1;
    phase_in   = 4'b0000;
    data_in    = 16'h0000;
    load_valid = 1'b0;
    tick();
    tick();
    check("rst.an", 16'(an_out), 16'hF);
    check("rst.seg", 16'(seg_out), 16'h7F);
    check("rst.fd", 16'(frame_done), 16'h0);
    check_err("rst", 2'd0, 1'b0);
    check("rst.ready", 16'(load_ready), 16'h1);

    // Load 1234 while waiting for sync; first frame still shows the reset value 0.
    reset      = 1'b0;
    load_valid = 1'b1;
    data_in    = 16'h1234;
    tick();
    load_valid = 1'b0;
    check("ld1.ready", 16'(load_ready), 16'h0);
    step("sync", 4'b0001, 4'b1110, 7'h40, 1'b0);
    step("f0.d1", 4'b0010, 4'b1101, 7'h7F, 1'b0);
    step("f0.d2", 4'b0100, 4'b1011, 7'h7F, 1'b0);
    step("f0.d3", 4'b1000, 4'b0111, 7'h7F, 1'b0);
    step("f1.d0", 4'b0001, 4'b1110, 7'h19, 1'b1);
    check("f1.ready", 16'(load_ready), 16'h1);
    step("f1.d1", 4'b0010, 4'b1101, 7'h30, 1'b0);
    step("f1.d2", 4'b0100, 4'b1011, 7'h24, 1'b0);
    step("f1.d3", 4'b1000, 4'b0111, 7'h79, 1'b0);
    step("f2.d0", 4'b0001, 4'b1110, 7'h19, 1'b1);

    // Leading-zero blanking: 0007 then 0000.
    load_valid = 1'b1;
    data_in    = 16'h0007;
    step("f2.d1", 4'b0010, 4'b1101, 7'h30, 1'b0);
    load_valid = 1'b0;
    step("f2.d2", 4'b0100, 4'b1011, 7'h24, 1'b0);
    step("f2.d3", 4'b1000, 4'b0111, 7'h79, 1'b0);
    step("lz7.d0", 4'b0001, 4'b1110, 7'h78, 1'b1);
    load_valid = 1'b1;
    data_in    = 16'h0000;
    step("lz7.d1", 4'b0010, 4'b1101, 7'h7F, 1'b0);
    load_valid = 1'b0;
    step("lz7.d2", 4'b0100, 4'b1011, 7'h7F, 1'b0);
    step("lz7.d3", 4'b1000, 4'b0111, 7'h7F, 1'b0);
    step("lz0.d0", 4'b0001, 4'b1110, 7'h40, 1'b1);
    step("lz0.d1", 4'b0010, 4'b1101, 7'h7F, 1'b0);
    step("lz0.d2", 4'b0100, 4'b1011, 7'h7F, 1'b0);
    step("lz0.d3", 4'b1000, 4'b0111, 7'h7F, 1'b0);
    step("lz0.d0b", 4'b0001, 4'b1110, 7'h40, 1'b1);

    // Ring held at 0001: legal stall.
    for (int i = 0; i < 5; i++) step("stall", 4'b0001, 4'b1110, 7'h40, 1'b0);
    check_err("stall", 2'd0, 1'b0);

    // Errors: non-one-hot, zero, skipped.
    step("err1", 4'b0101, 4'hF, 7'h7F, 1'b0);
    check_err("err1", 2'd1, 1'b0);
    step("ws.ign", 4'b0010, 4'hF, 7'h7F, 1'b0);
    check_err("ws.ign", 2'd1, 1'b0);
    step("resync1", 4'b0001, 4'b1110, 7'h40, 1'b0);
    step("rs1.d1", 4'b0010, 4'b1101, 7'h7F, 1'b0);
    step("err2", 4'b0000, 4'hF, 7'h7F, 1'b0);
    check_err("err2", 2'd2, 1'b0);
    step("resync2", 4'b0001, 4'b1110, 7'h40, 1'b0);
    step("err3", 4'b0100, 4'hF, 7'h7F, 1'b0);
    check_err("err3", 2'd3, 1'b1);
    step("fault.0001", 4'b0001, 4'hF, 7'h7F, 1'b0);
    step("fault.0010", 4'b0010, 4'hF, 7'h7F, 1'b0);
    check_err("fault", 2'd3, 1'b1);

    // Handshake still works in FAULT; reset then wins over a concurrent load.
    load_valid = 1'b1;
    data_in    = 16'h1234;
    tick();
    check("fault.ready", 16'(load_ready), 16'h0);
    reset = 1'b1;
    tick();
    check("rst2.ready", 16'(load_ready), 16'h1);
    check("rst2.an", 16'(an_out), 16'hF);
    check_err("rst2", 2'd0, 1'b0);

    // Second load held off until after the boundary; digit A blanks.
    reset   = 1'b0;
    data_in = 16'h0A98;
    tick();
    data_in = 16'h5555;
    check("pend.ready", 16'(load_ready), 16'h0);
    step("p.sync", 4'b0001, 4'b1110, 7'h40, 1'b0);
    check("p.ready0", 16'(load_ready), 16'h0);
    step("p.d1", 4'b0010, 4'b1101, 7'h7F, 1'b0);
    step("p.d2", 4'b0100, 4'b1011, 7'h7F, 1'b0);
    step("p.d3", 4'b1000, 4'b0111, 7'h7F, 1'b0);
    step("a.d0", 4'b0001, 4'b1110, 7'h00, 1'b1);
    check("a.ready", 16'(load_ready), 16'h1);
    step("a.d1", 4'b0010, 4'b1101, 7'h10, 1'b0);
    check("a.taken", 16'(load_ready), 16'h0);
    load_valid = 1'b0;
    step("a.d2", 4'b0100, 4'b1011, 7'h7F, 1'b0);
    step("a.d3", 4'b1000, 4'b0111, 7'h7F, 1'b0);
    step("b.d0", 4'b0001, 4'b1110, 7'h12, 1'b1);
    step("b.d1", 4'b0010, 4'b1101, 7'h12, 1'b0);

    // Mid-frame reset.
    reset = 1'b1;
    tick();
    check("rst3.an", 16'(an_out), 16'hF);
    check("rst3.seg", 16'(seg_out), 16'h7F);
    reset = 1'b0;
    step("rst3.sync", 4'b0001, 4'b1110, 7'h40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
